// File: rtl/pipe_addr_adder.sv
// rtl/pipe_addr_adder.sv - pipelined segmented WIDTH-bit add/sub with valid/ready flow control
// Optional macro ADDER_SAT_EN: clamp result on signed overflow in the final stage.
module pipe_addr_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SEG_W = WIDTH / STAGES;

  logic advance;

  // Index k is what stage k consumes; index 0 is the raw input side.
  logic             st_v [0:STAGES];
  logic [WIDTH-1:0] st_a [0:STAGES-1];
  logic [WIDTH-1:0] st_b [0:STAGES-1];
  logic [WIDTH-1:0] st_r [0:STAGES];
  logic             st_c [0:STAGES];
  logic             ovf_q;

  assign advance   = !st_v[STAGES] || out_ready;
  assign in_ready  = advance;

  assign st_v[0] = in_valid;
  assign st_a[0] = op_a;
  assign st_b[0] = op_sub ? ~op_b : op_b;
  assign st_r[0] = '0;
  assign st_c[0] = op_sub;

  assign out_valid = st_v[STAGES];
  assign result    = st_r[STAGES];
  assign carry_out = st_c[STAGES];
  assign overflow  = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W:0]   seg_sum;
    logic [WIDTH-1:0] nxt_r;

    assign seg_a   = SEG_W'(st_a[k] >> (k * SEG_W));
    assign seg_b   = SEG_W'(st_b[k] >> (k * SEG_W));
    assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, st_c[k]};

    always_comb begin
      nxt_r = st_r[k];
      nxt_r[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] r_q;

      // Datapath only loads behind a valid item; bubbles leave it untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= st_v[k];
          if (st_v[k]) begin
            a_q <= st_a[k];
            b_q <= st_b[k];
            r_q <= nxt_r;
            c_q <= seg_sum[SEG_W];
          end
        end
      end

      assign st_v[k+1] = v_q;
      assign st_a[k+1] = a_q;
      assign st_b[k+1] = b_q;
      assign st_r[k+1] = r_q;
      assign st_c[k+1] = c_q;
    end else begin : g_last
      logic             a_msb;
      logic             ovf_raw;
      logic [WIDTH-1:0] fin_r;
      logic             v_q;
      logic             c_q;
      logic             o_q;
      logic [WIDTH-1:0] r_q;

      assign a_msb   = st_a[k][WIDTH-1];
      assign ovf_raw = (a_msb == st_b[k][WIDTH-1]) && (nxt_r[WIDTH-1] != a_msb);

`ifdef ADDER_SAT_EN
      always_comb begin
        fin_r = nxt_r;
        if (ovf_raw) begin
          fin_r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign fin_r = nxt_r;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          r_q <= '0;
          c_q <= 1'b0;
          o_q <= 1'b0;
        end else if (advance) begin
          v_q <= st_v[k];
          if (st_v[k]) begin
            r_q <= fin_r;
            c_q <= seg_sum[SEG_W];
            o_q <= ovf_raw;
          end
        end
      end

      assign st_v[k+1] = v_q;
      assign st_r[k+1] = r_q;
      assign st_c[k+1] = c_q;
      assign ovf_q     = o_q;
    end
  end

endmodule
